// File: rtl/ips_conditioner.sv
// Front-end conditioner for motor_mv: synchronises and debounces the IPS/IR sensor inputs,
// stretches the IR obstacle flag, flags a lost line and strobes on any output change.
module ips_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned IR_HOLD_CYCLES  = 32,
  parameter logic [2:0]  LOST_PATTERN    = 3'b000,
  parameter int unsigned LOST_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] IPS_raw,
  input  logic       midIPS_raw,
  input  logic       IR_raw,
  output logic [1:0] IPS,
  output logic       midIPS,
  output logic       IR,
  output logic       line_lost,
  output logic       changed
);

  localparam int unsigned NB = 4;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(IR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOST_MAX  = CNT_W'(LOST_CYCLES);
  localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYCLES - 1);

  // Bit map for every per-sensor vector: [3:2] outer IPS, [1] middle IPS, [0] IR.
  logic [NB-1:0]    raw;
  logic [NB-1:0]    s1_q, s1_d;
  logic [NB-1:0]    s2_q, s2_d;
  logic [NB-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];

  logic             stretch_q, stretch_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic             line_lost_q, line_lost_d;
  logic [NB-1:0]    out_prev_q, out_prev_d;
  logic             changed_q, changed_d;

  logic             ir_db;
  logic             line_is_lost;
  logic [NB-1:0]    out_now;

  assign raw = {IPS_raw, midIPS_raw, IR_raw};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign ir_db = stable_q[0];

  // The stretch flop only carries the tail; the rising edge comes straight from ir_db.
  always_comb begin
    stretch_d = stretch_q;
    hold_d    = hold_q;
    if (ir_db) begin
      stretch_d = 1'b1;
      hold_d    = '0;
    end else if (stretch_q) begin
      if (hold_q == HOLD_LAST) begin
        stretch_d = 1'b0;
        hold_d    = '0;
      end else begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
  end

  assign line_is_lost = (stable_q[3:1] == LOST_PATTERN);

  always_comb begin
    lost_cnt_d  = '0;
    line_lost_d = 1'b0;
    if (line_is_lost) begin
      lost_cnt_d  = (lost_cnt_q == LOST_MAX) ? lost_cnt_q : lost_cnt_q + CNT_W'(1);
      line_lost_d = (lost_cnt_q >= LOST_LAST);
    end
  end

  assign out_now = {stable_q[3:1], ir_db | stretch_q};

  // Comparing against last cycle's outputs folds simultaneous bit changes into one pulse.
  always_comb begin
    out_prev_d = out_now;
    changed_d  = (out_now != out_prev_q);
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is
  // cleared in reset too, since a stale count would shorten the first debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stable_q    <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      stretch_q   <= 1'b0;
      hold_q      <= '0;
      lost_cnt_q  <= '0;
      line_lost_q <= 1'b0;
      out_prev_q  <= '0;
      changed_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      stretch_q   <= stretch_d;
      hold_q      <= hold_d;
      lost_cnt_q  <= lost_cnt_d;
      line_lost_q <= line_lost_d;
      out_prev_q  <= out_prev_d;
      changed_q   <= changed_d;
    end
  end

  assign IPS       = stable_q[3:2];
  assign midIPS    = stable_q[1];
  assign IR        = out_now[0];
  assign line_lost = line_lost_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_ips_conditioner.sv
// Directed bench for ips_conditioner: reset, debounce latency, glitch rejection,
// IR stretch, lost-line timing, mid-count reset and a stepped motor_mv-style sequence.
module tb_ips_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] IPS_raw;
  logic       midIPS_raw;
  logic       IR_raw;
  logic [1:0] IPS;
  logic       midIPS;
  logic       IR;
  logic       line_lost;
  logic       changed;

  int n_checks = 0;
  int n_errors = 0;

  ips_conditioner dut (
    .clk        (clk),
    .reset      (reset),
    .IPS_raw    (IPS_raw),
    .midIPS_raw (midIPS_raw),
    .IR_raw     (IR_raw),
    .IPS        (IPS),
    .midIPS     (midIPS),
    .IR         (IR),
    .line_lost  (line_lost),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after an edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [1:0] ips;
    logic       mid;
  } seq_t;

  seq_t seq [4];

  initial begin
    int         pulses;
    int         bad;
    logic [2:0] old_v;
    logic [2:0] new_v;

    seq[0] = '{2'b10, 1'b1};
    seq[1] = '{2'b01, 1'b1};
    seq[2] = '{2'b11, 1'b0};
    seq[3] = '{2'b00, 1'b0};

    // Reset with all raw inputs high.
    reset = 1'b1; IPS_raw = 2'b11; midIPS_raw = 1'b1; IR_raw = 1'b1;
    step(1);
    check("rst_first_edge", {IPS, midIPS, IR, line_lost, changed}, 0);
    step(2);
    check("rst_outputs", {IPS, midIPS, IR, line_lost, changed}, 0);
    reset = 1'b0;
    step(17);
    check("rel_edge17", {IPS, midIPS}, 3'b000);
    step(1);
    check("rel_edge18", {IPS, midIPS, IR}, 4'b1111);
    check("rel_changed_e18", changed, 0);
    step(1);
    check("rel_changed_e19", changed, 1);
    step(1);
    check("rel_changed_e20", changed, 0);

    // Glitch rejection on IPS[0].
    IPS_raw = 2'b10;
    step(40);
    check("glitch_base", IPS, 2'b10);
    IPS_raw = 2'b11;
    pulses = 0; bad = 0;
    for (int i = 0; i < 55; i++) begin
      if (i == 15) IPS_raw = 2'b10;
      step(1);
      pulses += int'(changed);
      if (IPS != 2'b10) bad++;
    end
    check("glitch15_ips", bad, 0);
    check("glitch15_changed", pulses, 0);
    IPS_raw = 2'b11;
    step(16);
    IPS_raw = 2'b10;
    step(1);
    check("pulse16_edge17", IPS, 2'b10);
    step(1);
    check("pulse16_edge18", IPS, 2'b11);
    step(40);
    check("pulse16_settle", IPS, 2'b10);

    // IR stretch.
    IR_raw = 1'b0;
    step(100);
    check("ir_idle", IR, 0);
    IR_raw = 1'b1;
    step(17);
    check("ir_rise_e17", IR, 0);
    step(1);
    check("ir_rise_e18", IR, 1);
    step(2);
    IR_raw = 1'b0;
    step(49);
    check("ir_fall_e49", IR, 1);
    step(1);
    check("ir_fall_e50", IR, 0);
    IR_raw = 1'b1;
    step(30);
    check("ir_reassert_up", IR, 1);
    IR_raw = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 20) IR_raw = 1'b1;
      step(1);
      if (IR != 1'b1) bad++;
    end
    check("ir_reassert_hold", bad, 0);

    // Lost line.
    IPS_raw = 2'b00; midIPS_raw = 1'b0;
    step(18);
    check("lost_pattern", {IPS, midIPS}, 3'b000);
    step(63);
    check("lost_e81", line_lost, 0);
    step(1);
    check("lost_e82", line_lost, 1);
    step(20);
    check("lost_sat", line_lost, 1);
    midIPS_raw = 1'b1;
    step(18);
    check("lost_mid_up", {midIPS, line_lost}, 2'b11);
    step(1);
    check("lost_clear", line_lost, 0);

    // Reset in the middle of a debounce count.
    IPS_raw = 2'b11;
    step(12);
    check("midrst_pre", IPS, 2'b00);
    reset = 1'b1;
    step(1);
    check("midrst_in", {IPS, midIPS, IR, line_lost, changed}, 0);
    step(1);
    check("midrst_in2", {IPS, midIPS, IR, line_lost, changed}, 0);
    reset = 1'b0;
    step(17);
    check("midrst_e17", {IPS, midIPS, IR}, 4'b0000);
    step(1);
    check("midrst_e18", {IPS, midIPS, IR}, 4'b1111);
    step(5);

    // Stepped motor_mv-style sequence, each step held 100 cycles.
    old_v = 3'b111;
    for (int s = 0; s < 4; s++) begin
      new_v = {seq[s].ips, seq[s].mid};
      IPS_raw = seq[s].ips; midIPS_raw = seq[s].mid;
      pulses = 0;
      for (int i = 1; i <= 100; i++) begin
        step(1);
        if (i == 17) check($sformatf("seq%0d_old", s), {IPS, midIPS}, old_v);
        if (i == 18) check($sformatf("seq%0d_new", s), {IPS, midIPS}, new_v);
        pulses += int'(changed);
      end
      check($sformatf("seq%0d_pulses", s), pulses, 1);
      old_v = new_v;
    end
    check("seq_lost", line_lost, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ips_conditioner.md
Name: ips_conditioner

Overview:
- Upstream front-end for motor_mv.
- Takes the raw, asynchronous line-tracking inputs (outer IPS pair, middle IPS) and the raw IR obstacle input. Synchronises and debounces each one, stretches the IR obstacle flag, and flags a lost line.
- Outputs connect directly to motor_mv's IPS[1:0], midIPS and IR inputs.
- All logic runs in the clk domain.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive mismatching samples required before a debounced output changes (minimum 1).
- CNT_W, 16: width of the debounce and hold counters. Must hold max(DEBOUNCE_CYCLES, IR_HOLD_CYCLES, LOST_CYCLES).
- IR_HOLD_CYCLES, 32: cycles the IR output stays high after the debounced IR falls.
- LOST_PATTERN, 3'b000: debounced {IPS[1:0], midIPS} value that means no line is seen.
- LOST_CYCLES, 64: consecutive cycles of LOST_PATTERN before line_lost asserts.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- IPS_raw  input  2  raw outer IPS sensors, asynchronous
- midIPS_raw  input  1  raw middle IPS sensor, asynchronous
- IR_raw  input  1  raw IR obstacle sensor, asynchronous
- IPS  output  2  debounced outer IPS, to motor_mv
- midIPS  output  1  debounced middle IPS, to motor_mv
- IR  output  1  debounced and stretched IR, to motor_mv
- line_lost  output  1  high while LOST_PATTERN has persisted at least LOST_CYCLES
- changed  output  1  one-cycle strobe when any of IPS, midIPS or IR changes value

Behaviour:
- Clock and reset: single clock, rising edge; synchronous, active-high reset.
- Reset: every flop clears to 0, including synchronisers, counters, hold timer and lost counter. Outputs are 0 on the first edge with reset high. Reset mid-operation aborts any count in progress; it has priority over all other logic.
- Synchronisation: each of the 4 raw bits passes through two flops (s1, s2). There is no other path from raw inputs to outputs.
- Debounce, per bit, each edge:
  - If s2 equals the stable value: count <= 0.
  - Else if count == DEBOUNCE_CYCLES-1: stable <= s2, count <= 0.
  - Else: count <= count+1.
- Debounce latency: a new raw level held constant from sampling edge E (edge 1) appears on the stable value at edge DEBOUNCE_CYCLES+2.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES samples at s2 produces no output change and restarts the count.
- IPS, midIPS: equal to their stable values.
- IR stretch, with ir_db the debounced IR:
  - ir_db = 1: IR <= 1 and hold <= 0. The rising edge passes with no extra latency beyond the debounce.
  - ir_db = 0 and IR = 1: hold <= hold+1. IR <= 0 on the edge where hold reaches IR_HOLD_CYCLES-1, so IR falls IR_HOLD_CYCLES edges after ir_db falls.
  - ir_db re-asserting during hold: clears hold and keeps IR high.
- line_lost:
  - lost_cnt increments, saturating at LOST_CYCLES, while {IPS, midIPS} == LOST_PATTERN. It clears to 0 on the first edge the pattern differs.
  - line_lost = (lost_cnt == LOST_CYCLES), registered. It deasserts on the edge after the pattern breaks.
- changed: registered; high for exactly one cycle after any edge where IPS, midIPS or IR took a new value. Simultaneous changes on several bits give one pulse, not several.
- Width rules: counters are CNT_W unsigned. Comparisons use parameter-1 constants, and no counter wraps.

Test Plan:
- Reset: hold reset 3 cycles with raw inputs = 1 -> all outputs 0. Release -> IPS becomes 2'b11 and midIPS 1 exactly DEBOUNCE_CYCLES+2 = 18 edges after the first sampling edge. changed pulses once, on the cycle after that update.
- Glitch rejection: IPS_raw[0] pulses 0->1 for 15 cycles, then returns to 0 -> IPS[0] stays 0 and changed never fires. A 16-cycle pulse -> IPS[0] rises at edge 18.
- IR stretch: IR_raw high for 20 cycles then low -> IR rises 18 edges after assertion and falls 18+32 = 50 edges after IR_raw falls. Re-asserting IR_raw during hold keeps IR high continuously.
- Lost line: all three IPS raw go 0 -> line_lost rises 64 edges after the debounced pattern reaches 000. midIPS_raw returning to 1 -> line_lost deasserts the edge after debounced midIPS rises.
- Reset mid-count: IPS_raw changes, reset pulses at count 10 -> outputs stay 0 during reset. After release the full 18-edge latency restarts from 0.
- Motor_mv-style sequence: step IPS_raw/midIPS_raw through 10/1, 01/1, 11/0, 00/0, each held 100 cycles -> debounced outputs follow each step 18 edges late, with one changed pulse per step.
